// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences weight load, weight shift, settle, activation load, execute and output drain for one corelet job.
// Define CORELET_CTRL_PERF_CNT_EN to build the perf_cycles busy-cycle counter; otherwise perf_cycles is tied to 0.
module corelet_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] n_vec,
  input  logic              relu_cfg,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              xw_mode,
  output logic              sfp_reset,
  output logic              relu_en,
  output logic [len_bw-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       perf_cycles
);
  localparam int CW = (len_bw > $clog2(row + col + 1)) ? len_bw : $clog2(row + col + 1);
  typedef enum logic [2:0] {IDLE, WLOAD, WSHIFT, KWAIT, XLOAD, EXEC, OUT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_d, nv_last;
  logic [len_bw-1:0] nv, nv_d, rd_d;
  logic [33:0] inst_d;
  logic relu_d, xw_d, sfp_d, busy_d, done_d;
  assign nv_last = CW'(nv) - CW'(1);
  always_comb begin
    nxt = state;
    cnt_d = cnt + CW'(1);
    nv_d = nv;
    relu_d = relu_en;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          nv_d = n_vec;
          relu_d = relu_cfg;
          nxt = (n_vec == '0) ? DONE : WLOAD;
        end
      end
      WLOAD:  if (cnt == CW'(col - 1)) begin nxt = WSHIFT; cnt_d = '0; end
      WSHIFT: if (cnt == CW'(col - 1)) begin nxt = KWAIT; cnt_d = '0; end
      KWAIT:  if (cnt == CW'(row + col - 1)) begin nxt = XLOAD; cnt_d = '0; end
      XLOAD:  if (cnt == nv_last) begin nxt = EXEC; cnt_d = '0; end
      EXEC:   if (cnt == nv_last) begin nxt = OUT; cnt_d = '0; end
      OUT: begin
        // cnt tallies rows actually read; inst[6] is the read issued this cycle
        cnt_d = cnt + CW'(inst[6]);
        if (inst[6] && cnt == nv_last) begin nxt = DONE; cnt_d = '0; end
      end
      DONE: begin nxt = IDLE; cnt_d = '0; end
      default: begin nxt = IDLE; cnt_d = '0; end
    endcase
    inst_d = '0;
    inst_d[0] = nxt == WSHIFT;
    inst_d[1] = nxt == EXEC;
    inst_d[2] = nxt == WLOAD || nxt == XLOAD;
    inst_d[3] = nxt == WSHIFT || nxt == EXEC;
    inst_d[6] = nxt == OUT && ofifo_valid;
    inst_d[7] = inst_d[6];
    xw_d = nxt == WLOAD || nxt == WSHIFT;
    sfp_d = state == IDLE && nxt == WLOAD;
    rd_d = nxt == WLOAD ? cnt_d[len_bw-1:0] :
           nxt == XLOAD ? len_bw'(col) + cnt_d[len_bw-1:0] : '0;
    busy_d = nxt != IDLE;
    done_d = nxt == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      nv <= '0;
      inst <= '0;
      xw_mode <= 1'b0;
      sfp_reset <= 1'b0;
      relu_en <= 1'b0;
      rd_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      nv <= nv_d;
      inst <= inst_d;
      xw_mode <= xw_d;
      sfp_reset <= sfp_d;
      relu_en <= relu_d;
      rd_addr <= rd_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
`ifdef CORELET_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_cycles <= '0;
    else if (state == IDLE && start) perf_cycles <= '0;
    else if (state != IDLE) perf_cycles <= perf_cycles + 32'd1;
  end
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: scoreboard bench; each job pushes its per-cycle expected outputs, a negedge monitor pops and compares.
// ofifo_valid sampled at edge c-1 decides the OFIFO read shown in cycle c; stall masks are indexed by that output cycle.
module tb_corelet_ctrl;
  logic clk = 1'b0, reset, start, relu_cfg, ofifo_valid;
  logic [7:0] n_vec, rd_addr;
  logic [33:0] inst;
  logic xw_mode, sfp_reset, relu_en, busy, done;
  logic [31:0] perf_cycles;
  typedef struct packed {
    logic [33:0] inst;
    logic xw, sfp, relu, busy, done;
    logic [7:0] rd;
  } rec_t;
  rec_t q[$];
  rec_t got, want;
  int tests = 0, fails = 0, c;
  logic cur_relu;
  logic [255:0] st;

  corelet_ctrl #(.row(8), .col(8), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .n_vec(n_vec), .relu_cfg(relu_cfg),
    .ofifo_valid(ofifo_valid), .inst(inst), .xw_mode(xw_mode), .sfp_reset(sfp_reset),
    .relu_en(relu_en), .rd_addr(rd_addr), .busy(busy), .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (reset) begin
      got = '{inst, xw_mode, sfp_reset, relu_en, busy, done, rd_addr};
      tests++;
      if (q.size() > 0) begin
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL seq t=%0t got inst=%h xw=%b sfp=%b relu=%b busy=%b done=%b rd=%0d want inst=%h xw=%b sfp=%b relu=%b busy=%b done=%b rd=%0d",
                   $time, got.inst, got.xw, got.sfp, got.relu, got.busy, got.done, got.rd,
                   want.inst, want.xw, want.sfp, want.relu, want.busy, want.done, want.rd);
        end
      end else if ({inst, xw_mode, sfp_reset, busy, done, rd_addr} !== '0) begin
        fails++;
        $display("FAIL idle t=%0t got inst=%h xw=%b sfp=%b busy=%b done=%b rd=%0d want all 0",
                 $time, inst, xw_mode, sfp_reset, busy, done, rd_addr);
      end
    end
  end

  task automatic push(input logic [33:0] i, input logic x, input logic s, input int r, input logic d);
    q.push_back('{i, x, s, cur_relu, 1'b1, d, r[7:0]});
    c++;
  endtask

  task automatic build(input int nv, input logic [255:0] stall, output int total);
    int reads;
    c = 1;
    if (nv != 0) begin
      for (int k = 0; k < 8; k++) push(34'h4, 1'b1, k == 0, k, 1'b0);
      for (int k = 0; k < 8; k++) push(34'h9, 1'b1, 1'b0, 0, 1'b0);
      for (int k = 0; k < 16; k++) push(34'h0, 1'b0, 1'b0, 0, 1'b0);
      for (int k = 0; k < nv; k++) push(34'h4, 1'b0, 1'b0, (8 + k) % 256, 1'b0);
      for (int k = 0; k < nv; k++) push(34'hA, 1'b0, 1'b0, 0, 1'b0);
      reads = 0;
      while (reads < nv && c < 250) begin
        if (stall[c]) push(34'h0, 1'b0, 1'b0, 0, 1'b0);
        else begin push(34'hC0, 1'b0, 1'b0, 0, 1'b0); reads++; end
      end
    end
    push(34'h0, 1'b0, 1'b0, 0, 1'b1);
    total = c - 1;
  endtask

  task automatic check_perf(input int exp_cycles, input string name);
    int want_p;
`ifdef CORELET_CTRL_PERF_CNT_EN
    want_p = exp_cycles;
`else
    want_p = 0;
`endif
    tests++;
    if (perf_cycles !== want_p[31:0]) begin
      fails++;
      $display("FAIL %s got perf_cycles=%0d want %0d", name, perf_cycles, want_p);
    end
  endtask

  task automatic run_job(input int nv, input logic relu, input logic [255:0] stall, input int abort_e, input int poke_e);
    int total, e;
    @(posedge clk); #1;
    start = 1'b1; n_vec = nv[7:0]; relu_cfg = relu; ofifo_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cur_relu = relu;
    build(nv, stall, total);
    e = 0;
    while (q.size() > 0 && e < 400) begin
      ofifo_valid = (e + 2 < 256) ? !stall[e + 2] : 1'b1;
      if (e == poke_e) begin start = 1'b1; n_vec = 8'd9; relu_cfg = !relu; end
      if (e == poke_e + 1) start = 1'b0;
      if (e == abort_e) begin
        #1 reset = 1'b0;
        q.delete();
        #1 tests++;
        if ({inst, xw_mode, sfp_reset, relu_en, rd_addr, busy, done, perf_cycles} !== '0) begin
          fails++;
          $display("FAIL abort_reset got inst=%h xw=%b sfp=%b relu=%b rd=%0d busy=%b done=%b perf=%0d want all 0",
                   inst, xw_mode, sfp_reset, relu_en, rd_addr, busy, done, perf_cycles);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        ofifo_valid = 1'b1;
        return;
      end
      @(posedge clk); #1;
      e++;
    end
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL timeout got %0d pending cycles want 0", q.size());
      q.delete();
    end
    ofifo_valid = 1'b1;
    check_perf(total, "perf_done");
    repeat (3) @(posedge clk);
    #1 check_perf(total, "perf_hold");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; n_vec = '0; relu_cfg = 1'b0; ofifo_valid = 1'b1;
    #3 tests++;
    if ({inst, xw_mode, sfp_reset, relu_en, rd_addr, busy, done, perf_cycles} !== '0) begin
      fails++;
      $display("FAIL reset_state got inst=%h busy=%b done=%b perf=%0d want all 0", inst, busy, done, perf_cycles);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_job(4, 1'b1, '0, -1, -1);
    st = '0; st[42] = 1'b1; st[43] = 1'b1; st[44] = 1'b1;
    run_job(4, 1'b0, st, -1, -1);
    run_job(0, 1'b1, '0, -1, -1);
    run_job(4, 1'b1, '0, 37, -1);
    run_job(4, 1'b1, '0, -1, -1);
    run_job(4, 1'b0, '0, -1, 20);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
